uart2_rx: RTL and testbench
===========================

Name: uart2_rx

Overview:
- Serial UART receiver, 8N1, LSB first. Companion to the UART2 transmit path: samples line rx2 and recovers parallel bytes.
- Runs entirely on the system clock clk_sis. A per-bit counter divides the clock down to the bit rate; there is no separate UART clock.
- Presents each byte with a level-held ready/ack handshake. Flags framing and overrun errors.

Parameters:
- CLKS_PER_BIT, 16, clk_sis cycles per serial bit. Must be even and >= 4.
- DATA_BITS, 8, data bits per frame. Fixed at 8 for this release.

Ports:
- clk_sis  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx2  input  1  serial line; idle high; asynchronous to clk_sis.
- data_ack  input  1  consumer acknowledge; one-cycle pulse or level.
- data_out  output  8  last good received byte.
- data_ready  output  1  data_out holds an unacknowledged byte.
- frame_err  output  1  last frame had stop bit = 0.
- overrun  output  1  a byte was overwritten before it was acknowledged.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE; counters = 0.
  - Both synchronizer flops = 1.
  - data_out = 8'h00; data_ready, frame_err, overrun, busy = 0.
  - Deasserting reset mid-frame leaves the block in IDLE, waiting for a fresh falling edge.
- Synchronizer: two-flop on rx2. Below, rxs means the synchronized value. Pin-to-rxs latency is 2 cycles.
- bit_cnt counts 0..CLKS_PER_BIT-1. bit_idx counts 0..7.
- IDLE:
  - On rxs=0, go to START with bit_cnt=0.
- START:
  - At bit_cnt = CLKS_PER_BIT/2-1 (mid start bit), sample rxs.
  - rxs=0: go to DATA, bit_cnt=0, bit_idx=0.
  - rxs=1: treat as a glitch and return to IDLE. No flags change.
- DATA:
  - At bit_cnt = CLKS_PER_BIT-1, shift rxs into shift_reg MSB (LSB-first assembly), reset bit_cnt, increment bit_idx.
  - After bit_idx=7 is sampled, go to STOP.
- STOP:
  - At bit_cnt = CLKS_PER_BIT-1, sample rxs.
  - rxs=1 (good frame):
    - data_out <= shift_reg; data_ready <= 1; frame_err <= 0.
    - If data_ready was already 1 and data_ack is not asserted this cycle, set overrun <= 1.
    - Go to IDLE.
  - rxs=0 (bad frame):
    - frame_err <= 1. data_out and data_ready are unchanged.
    - Go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rxs=1, then go to IDLE. This prevents a break condition from retriggering a frame.
- Handshake:
  - data_ack=1 clears data_ready and overrun on the next edge.
  - frame_err stays sticky until the next completed frame or reset.
  - Ack and good-stop in the same cycle: the new byte wins. data_ready stays 1, data_out updates, overrun stays 0.
  - data_ack while data_ready=0 has no effect.
- Latency:
  - data_ready rises exactly 2 + 1 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clk_sis edges after the rx2 pin falling edge, sampled at a clk_sis edge.
  - Bench tolerance is +/-1 cycle, to cover pin-to-edge phase.
- busy: 1 in START, DATA, STOP and WAIT_IDLE.
- Tolerance: mid-bit sampling tolerates about +/-40% of a bit of accumulated drift across the frame.

Test Plan:
- T1 nominal: CLKS_PER_BIT=16; send start, 8'h5B LSB first (1,1,0,1,1,0,1,0), stop=1 -> data_out=8'h5B, data_ready=1 at 2+1+8+144 cycles (+/-1), frame_err=0. Pulse data_ack -> data_ready=0 next cycle.
- T2 glitch: drive rx2 low for 4 cycles, then high -> busy pulses, returns to IDLE; data_ready and frame_err stay 0.
- T3 framing: send 8'hA5 with stop=0 and hold rx2 low for 40 cycles -> frame_err=1, data_ready=0, busy=1 until rx2 returns high. Then send 8'h3C with a valid stop -> data_out=8'h3C, frame_err=0.
- T4 overrun: send 8'h12 then 8'h34 back-to-back with no ack -> data_out=8'h34, data_ready=1, overrun=1. data_ack -> both clear.
- T5 simultaneous: assert data_ack on the cycle the second byte's stop is sampled -> data_ready stays 1, data_out=new byte, overrun=0.
- T6 reset mid-frame: pull rst low during data bit 3 of 8'hFF -> all outputs 0 immediately. Release rst, then send 8'h00 -> data_out=8'h00, data_ready=1.

Source files
------------

// File: rtl/uart2_rx.sv
// 8N1 UART receiver clocked entirely by clk_sis; a per-bit counter provides mid-bit sampling.
// Received bytes are held behind a level ready/ack handshake with framing and overrun flags.
module uart2_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic       clk_sis,
  input  logic       rst,
  input  logic       rx2,
  input  logic       data_ack,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]      IdxLast = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rxs;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            ready_q, ready_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;

  assign rxs = sync_q[1];

  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) begin
      sync_q    <= 2'b11;
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx2};
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ready_d   = ready_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;

    // Ack is applied first so a good stop in the same cycle overrides it (new byte wins).
    if (data_ack) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        if (!rxs) state_d = StStart;
      end
      StStart: begin
        if (bit_cnt_q == CntHalf) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rxs ? StIdle : StData;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      StData: begin
        if (bit_cnt_q == CntLast) begin
          bit_cnt_d = '0;
          shift_d   = {rxs, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == IdxLast) state_d = StStop;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_cnt_q == CntLast) begin
          bit_cnt_d = '0;
          if (rxs) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            ferr_d  = 1'b0;
            if (ready_q && !data_ack) ovr_d = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitIdle;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      StWaitIdle: begin
        // A held-low line (break) must not be taken as a new start bit.
        if (rxs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign data_out   = data_q;
  assign data_ready = ready_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart2_rx.sv
// Directed plus randomized bench for uart2_rx, checked against a frame-level handshake model.
module tb_uart2_rx;
  localparam int C = 16;
  localparam int Latency = 2 + 1 + C / 2 + 9 * C;

  logic       clk_sis = 1'b0;
  logic       rst = 1'b0;
  logic       rx2 = 1'b1;
  logic       data_ack = 1'b0;
  logic [7:0] data_out;
  logic       data_ready, frame_err, overrun, busy;

  int total = 0;
  int bad = 0;
  int rise_n;

  logic [7:0] m_data;
  logic       m_ready, m_ovr, m_ferr;

  uart2_rx #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
    .clk_sis   (clk_sis),
    .rst       (rst),
    .rx2       (rx2),
    .data_ack  (data_ack),
    .data_out  (data_out),
    .data_ready(data_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk_sis = ~clk_sis;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"}, data_out, m_data);
    check({tag, ".ready"}, {7'd0, data_ready}, {7'd0, m_ready});
    check({tag, ".ferr"}, {7'd0, frame_err}, {7'd0, m_ferr});
    check({tag, ".ovr"}, {7'd0, overrun}, {7'd0, m_ovr});
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_ready = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  // Frame-level effect: ack_in_stop means data_ack was high on the stop-sample edge.
  task automatic model_frame(input logic [7:0] b, input logic stop, input logic ack_in_stop);
    if (stop) begin
      m_ovr   = ack_in_stop ? 1'b0 : (m_ovr | m_ready);
      m_ready = 1'b1;
      m_data  = b;
      m_ferr  = 1'b0;
    end else begin
      m_ferr = 1'b1;
      if (ack_in_stop) begin
        m_ready = 1'b0;
        m_ovr   = 1'b0;
      end
    end
  endtask

  task automatic pulse_ack();
    @(negedge clk_sis) data_ack = 1'b1;
    @(negedge clk_sis) data_ack = 1'b0;
    m_ready = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Drives one frame, one pin value per negedge; index 0 is the start-bit falling edge.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_at,
                            input int stop_after);
    logic [9:0] bits;
    logic       prev;
    bits   = {stop, b, 1'b0};
    rise_n = -1;
    prev   = data_ready;
    for (int n = 0; n < 10 * C && n < stop_after; n++) begin
      @(negedge clk_sis);
      if (data_ready && !prev && rise_n < 0) rise_n = n;
      prev     = data_ready;
      rx2      = bits[n / C];
      data_ack = (n == ack_at);
    end
  endtask

  task automatic recover();
    @(negedge clk_sis) rx2 = 1'b1;
    repeat (5) @(negedge clk_sis);
  endtask

  initial begin
    logic       saw_busy;
    logic [7:0] b;
    logic       stop, ack_same;

    model_reset();
    repeat (3) @(negedge clk_sis);
    check_all("reset");
    check("reset.busy", {7'd0, busy}, 8'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk_sis);

    // T1 nominal byte and latency
    send_frame(8'h5B, 1'b1, -1, 1000);
    model_frame(8'h5B, 1'b1, 1'b0);
    check_all("t1");
    total++;
    assert (rise_n >= Latency - 1 && rise_n <= Latency + 1) else begin
      bad++;
      $error("FAIL t1.latency: observed=%0d expected=%0d", rise_n, Latency);
    end
    check("t1.busy", {7'd0, busy}, 8'd0);
    pulse_ack();
    check_all("t1.ack");

    // T2 short glitch on the line
    saw_busy = 1'b0;
    @(negedge clk_sis) rx2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sis);
      saw_busy |= busy;
      if (i == 3) rx2 = 1'b1;
    end
    check("t2.saw_busy", {7'd0, saw_busy}, 8'd1);
    check("t2.busy", {7'd0, busy}, 8'd0);
    check_all("t2");

    // T3 framing error with line held low, then a good frame
    send_frame(8'hA5, 1'b0, -1, 1000);
    model_frame(8'hA5, 1'b0, 1'b0);
    repeat (40) @(negedge clk_sis);
    check_all("t3.bad");
    check("t3.busy_low", {7'd0, busy}, 8'd1);
    recover();
    check("t3.busy_idle", {7'd0, busy}, 8'd0);
    send_frame(8'h3C, 1'b1, -1, 1000);
    model_frame(8'h3C, 1'b1, 1'b0);
    check_all("t3.good");
    pulse_ack();

    // T4 overrun
    send_frame(8'h12, 1'b1, -1, 1000);
    model_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, -1, 1000);
    model_frame(8'h34, 1'b1, 1'b0);
    check_all("t4.ovr");
    check("t4.ovr_set", {7'd0, overrun}, 8'd1);
    pulse_ack();
    check_all("t4.ack");

    // T5 ack on the stop-sample edge of the second byte
    send_frame(8'h56, 1'b1, -1, 1000);
    model_frame(8'h56, 1'b1, 1'b0);
    send_frame(8'h78, 1'b1, Latency - 1, 1000);
    model_frame(8'h78, 1'b1, 1'b1);
    check_all("t5");

    // T6 reset during data bit 3
    send_frame(8'hFF, 1'b1, -1, 4 * C + C / 2);
    rst = 1'b0;
    #1;
    model_reset();
    check_all("t6.rst");
    check("t6.busy", {7'd0, busy}, 8'd0);
    @(negedge clk_sis) rx2 = 1'b1;
    repeat (2) @(negedge clk_sis);
    rst = 1'b1;
    repeat (3) @(negedge clk_sis);
    send_frame(8'h00, 1'b1, -1, 1000);
    model_frame(8'h00, 1'b1, 1'b0);
    check_all("t6.after");

    // Randomized frames, stop bits and ack timing
    for (int k = 0; k < 12; k++) begin
      b        = 8'($urandom);
      stop     = ($urandom_range(0, 3) != 0);
      ack_same = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) pulse_ack();
      send_frame(b, stop, ack_same ? Latency - 1 : -1, 1000);
      model_frame(b, stop, ack_same);
      if (!stop) recover();
      check_all($sformatf("rand%0d", k));
      check($sformatf("rand%0d.busy", k), {7'd0, busy}, 8'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
